// File: rtl/fifo_bh_frame_packer.sv
// rtl/fifo_bh_frame_packer.sv - packs show-ahead FIFO words into header/payload/checksum frames
// One output register; the FSM only loads it when the slot is free, so backpressure never pops.
module fifo_bh_frame_packer #(
  parameter int unsigned FRAME_WORDS = 8,
  parameter logic [15:0] SYNC        = 16'hA55A
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fifo_empty_i,
  input  logic [31:0] fifo_rdata_i,
  output logic        fifo_rden_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [31:0] m_data_o,
  output logic        m_last_o,
  output logic [15:0] frame_count_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, PAYLOAD = 2'd1, TRAILER = 2'd2} state_t;

  localparam logic [15:0] LAST_IDX = 16'(FRAME_WORDS - 1);

  state_t      state_q, state_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] sum_q, sum_d;
  logic [31:0] load_data;
  logic        load, load_last, slot_free;

  assign slot_free     = !m_valid_o || m_ready_i;
  assign frame_count_o = frame_cnt_q;
  assign busy_o        = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    frame_cnt_d = frame_cnt_q;
    sum_d       = sum_q;
    load        = 1'b0;
    load_data   = 32'h0;
    load_last   = 1'b0;
    fifo_rden_o = 1'b0;
    case (state_q)
      IDLE: begin
        // Header waits for a payload word so a frame never starts empty.
        if (!fifo_empty_i && slot_free) begin
          load       = 1'b1;
          load_data  = {SYNC, frame_cnt_q};
          word_cnt_d = 16'h0;
          sum_d      = 32'h0;
          state_d    = PAYLOAD;
        end
      end
      PAYLOAD: begin
        fifo_rden_o = !fifo_empty_i && slot_free;
        if (fifo_rden_o) begin
          load       = 1'b1;
          load_data  = fifo_rdata_i;
          sum_d      = sum_q + fifo_rdata_i;
          word_cnt_d = word_cnt_q + 16'h1;
          if (word_cnt_q == LAST_IDX) state_d = TRAILER;
        end
      end
      TRAILER: begin
        if (slot_free) begin
          load        = 1'b1;
          load_data   = sum_q;
          load_last   = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'h1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      word_cnt_q  <= 16'h0;
      frame_cnt_q <= 16'h0;
      sum_q       <= 32'h0;
      m_valid_o   <= 1'b0;
      m_data_o    <= 32'h0;
      m_last_o    <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      sum_q       <= sum_d;
      if (load) begin
        m_valid_o <= 1'b1;
        m_data_o  <= load_data;
        m_last_o  <= load_last;
      end else if (slot_free) begin
        m_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fifo_bh_frame_packer.md
# fifo_bh_frame_packer

Read-side consumer for the `fifo_bh_*` clock-crossing FIFOs, running entirely in the FIFO read clock domain. It drains 32-bit words from the FIFO's show-ahead read port (`empty` low means `dout` holds the head word; `rd_en` pops it). It groups `FRAME_WORDS` payload words into a frame, with a header word before the payload and a checksum word after it. Frames leave on a valid/ready stream toward the transmit or measurement-capture logic.

## Interface
- `FRAME_WORDS`, default 8: payload words per frame; legal range 1–65535.
- `SYNC`, default 16'hA55A: upper half of every header word.
- `clk` input 1: FIFO read clock; all logic on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `fifo_empty_i` input 1: FIFO empty flag; low means `fifo_rdata_i` is valid.
- `fifo_rdata_i` input 32: FIFO head word.
- `fifo_rden_o` output 1: pops the FIFO head word. Combinational.
- `m_valid_o` output 1: output word valid. Registered.
- `m_ready_i` input 1: downstream accepts the word.
- `m_data_o` output 32: output word. Registered.
- `m_last_o` output 1: marks the checksum word, the last word of a frame. Registered.
- `frame_count_o` output 16: number of frames whose checksum word has been loaded. Wraps at 16 bits.
- `busy_o` output 1: high when the state is not IDLE.

## Operation
- The block has a single output register holding `m_valid_o`, `m_data_o` and `m_last_o`.
- `slot_free` = `!m_valid_o || m_ready_i`. The register loads only when `slot_free` is high.
- If `slot_free` is high and nothing is loaded in that cycle, `m_valid_o` clears.
- State machine states and transitions:
  - **IDLE**: if `!fifo_empty_i && slot_free`:
    - load header `{SYNC, frame_cnt}`, with `m_last_o` = 0;
    - clear `word_cnt` and `sum`;
    - go to PAYLOAD.
    - No FIFO pop on this cycle. A header is never emitted before at least one payload word is available.
  - **PAYLOAD**: `fifo_rden_o` = `!fifo_empty_i && slot_free`. When `fifo_rden_o` is high:
    - load `fifo_rdata_i`, with `m_last_o` = 0;
    - `sum` ← `sum + fifo_rdata_i` (mod 2^32);
    - `word_cnt` ← `word_cnt + 1`;
    - if `word_cnt == FRAME_WORDS-1` (counter value before the increment), go to TRAILER.
  - **TRAILER**: if `slot_free`:
    - load `sum`, with `m_last_o` = 1;
    - `frame_cnt` ← `frame_cnt + 1` (wraps 16'hFFFF → 0);
    - go to IDLE.
- `fifo_rden_o` is 0 in IDLE and TRAILER. It is never high while `fifo_empty_i` is high.
- `word_cnt` is 16 bits wide. `sum` is 32 bits and discards any carry out.
- `frame_count_o` = `frame_cnt`.
- Starvation mid-frame: the block stays in PAYLOAD indefinitely. `m_valid_o` drops once the held word is accepted. There is no timeout and no padding.
- Backpressure: the output register holds its contents stable while `m_valid_o && !m_ready_i`. No pop occurs while the output register is blocked.

## Timing
- Reset values, applied asynchronously on `reset_n` low:
  - state = IDLE;
  - `m_valid_o`, `m_last_o` = 0; `m_data_o` = 0;
  - `frame_cnt`, `word_cnt`, `sum` = 0;
  - `busy_o` = 0.
- `fifo_rden_o` may still be combinationally high during reset only if the state is PAYLOAD. Since reset forces IDLE, it is 0 throughout reset.
- Reset mid-frame abandons the partial frame. Words already popped are lost. The first frame after reset has header 32'hA55A0000.
- Latency: `fifo_empty_i` low in cycle N (state IDLE, slot free) → header visible with `m_valid_o` high after edge N. The first payload word is popped in cycle N+1.
- Throughput with `m_ready_i` held high and the FIFO never empty:
  - one word per cycle, `FRAME_WORDS+2` cycles per frame;
  - back-to-back frames have no bubble (the cycle after TRAILER loads the next header).
- `m_last_o` is high for exactly one accepted word per frame.

## Test plan
- **Single frame** (`FRAME_WORDS`=4), FIFO holds 1,2,3,4, `m_ready_i`=1:
  - stream is 32'hA55A0000, 1, 2, 3, 4, 32'h0000000A;
  - `m_last_o` is high only on 0000000A;
  - `frame_count_o` = 1; `busy_o` ends at 0.
- **Two consecutive frames**:
  - second header is 32'hA55A0001;
  - the 12 output words arrive in 12 consecutive cycles;
  - `frame_count_o` = 2.
- **Checksum wrap**: `FRAME_WORDS`=2, payload 32'hFFFFFFFF, 32'h00000002 → trailer 32'h00000001.
- **Backpressure**: `m_ready_i` low for 5 cycles mid-payload:
  - `m_data_o` stable;
  - `fifo_rden_o` = 0 throughout;
  - no word lost or duplicated.
- **Starvation**: FIFO empty after 2 of 4 payload words for 10 cycles:
  - `busy_o` stays 1; `m_valid_o` goes 0;
  - the frame resumes correctly and the trailer sum is correct.
- **Reset mid-PAYLOAD**:
  - all outputs return to their reset values immediately;
  - the next frame header is 32'hA55A0000.
